ball_vga_renderer: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_sync_counter.sv | 42 ++++
 rtl/ball_vga_renderer.sv | 93 +++++++++
 tb/tb_ball_vga_renderer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, colours and helpers for the ball renderer.
// Coordinates are 10 bits; span compares are done at 11 bits so sums never wrap.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int          DEF_BALL_SIZE = 16;
  localparam logic [11:0] DEF_BALL_RGB  = 12'hF00;
  localparam logic [11:0] DEF_BG_RGB    = 12'h000;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] rgb;
  } vga_out_t;

  localparam vga_out_t VGA_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, rgb: 12'h000};

  // True when lo <= v < lo+len; the extra bit keeps lo+len from wrapping.
  function automatic logic in_span(input logic [COORD_W:0] v,
                                   input logic [COORD_W:0] lo,
                                   input logic [COORD_W:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters that advance only on pix_en strobes.
// Both counters return to (0,0) together at the last pixel of the frame.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               line_start
);

  logic line_wrap;
  logic frame_wrap;

  if (H_TOTAL > 2 ** COORD_W || V_TOTAL > 2 ** COORD_W) begin : g_size_check
    $error("vga_sync_counter: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  assign line_wrap  = (h_cnt == COORD_W'(H_TOTAL - 1));
  assign frame_wrap = line_wrap && (v_cnt == COORD_W'(V_TOTAL - 1));
  assign line_start = (h_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_wrap) begin
        h_cnt <= '0;
        v_cnt <= frame_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_vga_renderer.sv
// VGA renderer: draws a square ball on a plain background with 1-pixel output latency.
// The ball position is sampled once per frame at the start of vertical blanking.
module ball_vga_renderer
  import vga_timing_pkg::*;
#(
  parameter int          H_ACTIVE  = DEF_H_ACTIVE,
  parameter int          H_FP      = DEF_H_FP,
  parameter int          H_SYNC    = DEF_H_SYNC,
  parameter int          H_BP      = DEF_H_BP,
  parameter int          V_ACTIVE  = DEF_V_ACTIVE,
  parameter int          V_FP      = DEF_V_FP,
  parameter int          V_SYNC    = DEF_V_SYNC,
  parameter int          V_BP      = DEF_V_BP,
  parameter int          BALL_SIZE = DEF_BALL_SIZE,
  parameter logic [11:0] BALL_RGB  = DEF_BALL_RGB,
  parameter logic [11:0] BG_RGB    = DEF_BG_RGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic               line_start;
  logic               vblank_start;
  logic               hit;
  vga_out_t           pix_next;
  vga_out_t           pix_q;

  vga_sync_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .line_start(line_start)
  );

  assign vblank_start = line_start && (v_cnt == COORD_W'(V_ACTIVE));

  always_comb begin
    pix_next = VGA_IDLE;
    hit      = in_span({1'b0, h_cnt}, {1'b0, ball_x}, 11'(BALL_SIZE)) &&
               in_span({1'b0, v_cnt}, {1'b0, ball_y}, 11'(BALL_SIZE));
    pix_next.de    = (h_cnt < COORD_W'(H_ACTIVE)) && (v_cnt < COORD_W'(V_ACTIVE));
    pix_next.hsync = !in_span({1'b0, h_cnt}, 11'(H_ACTIVE + H_FP), 11'(H_SYNC));
    pix_next.vsync = !in_span({1'b0, v_cnt}, 11'(V_ACTIVE + V_FP), 11'(V_SYNC));
    if (pix_next.de) begin
      pix_next.rgb = hit ? BALL_RGB : BG_RGB;
    end
  end

  // The tick follows the latching edge by one clk and drops on the next clk regardless of pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q      <= VGA_IDLE;
      ball_x     <= '0;
      ball_y     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && vblank_start;
      if (pix_en) begin
        pix_q <= pix_next;
        if (vblank_start) begin
          ball_x <= pos_x;
          ball_y <= pos_y;
        end
      end
    end
  end

  assign hsync = pix_q.hsync;
  assign vsync = pix_q.vsync;
  assign de    = pix_q.de;
  assign rgb   = pix_q.rgb;

endmodule

// File: tb/tb_ball_vga_renderer.sv
// Self-checking bench: a reduced-timing instance and a default 640x480 instance,
// both compared every clk against a raster model built from strobe counts.
module tb_ball_vga_renderer;

  localparam int SH_A = 40, SH_FP = 4, SH_S = 6, SH_BP = 6;
  localparam int SV_A = 30, SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int SHT = SH_A + SH_FP + SH_S + SH_BP;
  localparam int SVT = SV_A + SV_FP + SV_S + SV_BP;
  localparam int SFRAME = SHT * SVT;
  localparam int SBS = 6;
  localparam logic [11:0] SBALL = 12'h0F0;
  localparam logic [11:0] SBG   = 12'h00F;
  localparam int BHT = 800, BVT = 525;
  localparam int TICK_BUDGET = 5 * SFRAME;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        s_hsync, s_vsync, s_de, s_tick;
  logic [11:0] s_rgb;
  logic        b_hsync, b_vsync, b_de, b_tick;
  logic [11:0] b_rgb;

  int errors = 0;
  int checks = 0;
  int en_mode = 0;
  int cyc = 0;

  int s_n, b_n, s_bx, s_by, b_bx, b_by;
  logic [14:0] s_exp, b_exp;
  logic        s_tick_exp, b_tick_exp;
  bit          armed = 0;
  int s_ball_cnt = 0, s_strobe_cnt = 0, s_tick_cnt = 0;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    int         balls;
  } vec_t;
  vec_t vecs[9];

  ball_vga_renderer #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
    .BALL_SIZE(SBS), .BALL_RGB(SBALL), .BG_RGB(SBG)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pos_x(pos_x), .pos_y(pos_y),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .rgb(s_rgb), .frame_tick(s_tick)
  );

  ball_vga_renderer u_big (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pos_x(pos_x), .pos_y(pos_y),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .rgb(b_rgb), .frame_tick(b_tick)
  );

  initial forever #5 clk = ~clk;

  // Expected {hsync, vsync, de, rgb} for the raster pixel (x, y).
  function automatic logic [14:0] ref_pixel(int x, int y, int bx, int by, int ha, int hfp, int hs,
                                            int va, int vfp, int vs, int bs,
                                            logic [11:0] bc, logic [11:0] gc);
    logic        d, hn, vn;
    logic [11:0] c;
    d  = (x < ha) && (y < va);
    hn = !((x >= ha + hfp) && (x < ha + hfp + hs));
    vn = !((y >= va + vfp) && (y < va + vfp + vs));
    c  = 12'h000;
    if (d) c = ((x >= bx) && (x < bx + bs) && (y >= by) && (y < by + bs)) ? bc : gc;
    return {hn, vn, d, c};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Input driver for pix_en duty patterns and random positions.
  initial forever begin
    @(negedge clk);
    cyc++;
    case (en_mode)
      1: pix_en = (cyc % 4 == 0);
      2: begin
        pix_en = ($urandom_range(0, 1) == 1);
        pos_x  = 10'($urandom_range(0, 45));
        pos_y  = 10'($urandom_range(0, 35));
      end
      default: pix_en = 1'b1;
    endcase
  end

  // Reference model: raster position is the strobe count since reset.
  initial forever begin
    logic in_rst, in_en;
    logic [9:0] in_x, in_y;
    int sx, sy, bx, by;
    @(posedge clk);
    in_rst = rst; in_en = pix_en; in_x = pos_x; in_y = pos_y;
    if (in_rst === 1'b1) begin
      armed = 1;
      s_n = 0; b_n = 0; s_bx = 0; s_by = 0; b_bx = 0; b_by = 0;
      s_exp = {1'b1, 1'b1, 1'b0, 12'h000};
      b_exp = {1'b1, 1'b1, 1'b0, 12'h000};
      s_tick_exp = 0; b_tick_exp = 0;
    end else if (armed) begin
      sx = s_n % SHT; sy = (s_n / SHT) % SVT;
      bx = b_n % BHT; by = (b_n / BHT) % BVT;
      s_tick_exp = in_en && sx == 0 && sy == SV_A;
      b_tick_exp = in_en && bx == 0 && by == 480;
      if (in_en) begin
        s_exp = ref_pixel(sx, sy, s_bx, s_by, SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S, SBS, SBALL, SBG);
        b_exp = ref_pixel(bx, by, b_bx, b_by, 640, 16, 96, 480, 10, 2, 16, 12'hF00, 12'h000);
        if (s_tick_exp) begin s_bx = in_x; s_by = in_y; end
        if (b_tick_exp) begin b_bx = in_x; b_by = in_y; end
        s_n++; b_n++;
      end
    end
    #1;
    if (armed) begin
      check_output("s_pixel", {17'b0, s_hsync, s_vsync, s_de, s_rgb}, {17'b0, s_exp});
      check_output("s_tick", {31'b0, s_tick}, {31'b0, s_tick_exp});
      check_output("b_pixel", {17'b0, b_hsync, b_vsync, b_de, b_rgb}, {17'b0, b_exp});
      check_output("b_tick", {31'b0, b_tick}, {31'b0, b_tick_exp});
      if (in_en && !in_rst) begin
        s_strobe_cnt++;
        if (s_de === 1'b1 && s_rgb === SBALL) s_ball_cnt++;
      end
      if (s_tick === 1'b1) s_tick_cnt++;
    end
  end

  task automatic wait_tick(input string name);
    int  start;
    bit  ok;
    start = s_tick_cnt;
    ok = 0;
    for (int i = 0; i < TICK_BUDGET && !ok; i++) begin
      @(negedge clk);
      ok = (s_tick_cnt != start);
    end
    check_output(name, {31'b0, ok}, 32'd1);
  endtask

  // Counts ball pixels and strobes from one frame_tick to the next.
  task automatic run_frame(input string name, input int change_at, input logic [9:0] nx,
                           input logic [9:0] ny, input int exp_balls);
    int start;
    bit ok;
    s_ball_cnt = 0;
    s_strobe_cnt = 0;
    start = s_tick_cnt;
    ok = 0;
    for (int i = 0; i < TICK_BUDGET && !ok; i++) begin
      @(negedge clk);
      if (s_strobe_cnt == change_at) begin pos_x = nx; pos_y = ny; end
      ok = (s_tick_cnt != start);
    end
    check_output({name, "_tick"}, {31'b0, ok}, 32'd1);
    check_output({name, "_balls"}, s_ball_cnt, exp_balls);
    check_output({name, "_period"}, s_strobe_cnt, SFRAME);
  endtask

  task automatic apply_stimulus();
    int de_cnt, hs_cnt, hs_first, guard;
    bit found;

    vecs[0] = '{10'd10, 10'd5, 36};
    vecs[1] = '{10'd37, 10'd27, 9};
    vecs[2] = '{10'd40, 10'd5, 0};
    vecs[3] = '{10'd0, 10'd0, 36};
    vecs[4] = '{10'd5, 10'd28, 12};
    vecs[5] = '{10'd39, 10'd29, 1};
    vecs[6] = '{10'd1023, 10'd1023, 0};
    vecs[7] = '{10'd38, 10'd0, 12};
    vecs[8] = '{10'd2, 10'd30, 0};

    rst = 1'b1; pos_x = '0; pos_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_hsync", {31'b0, s_hsync}, 32'd1);
    check_output("rst_de", {31'b0, b_de}, 32'd0);
    rst = 1'b0;

    de_cnt = 0; hs_cnt = 0; hs_first = -1;
    for (int k = 1; k <= BHT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_output("first_de", {31'b0, s_de}, 32'd1);
        check_output("first_rgb", {20'b0, s_rgb}, {20'b0, SBALL});
      end
      if (b_de === 1'b1) de_cnt++;
      if (b_hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
    end
    check_output("line_de_count", de_cnt, 640);
    check_output("line_hsync_count", hs_cnt, 96);
    check_output("line_hsync_start", hs_first, 657);

    for (int i = 0; i < 9; i++) begin
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      wait_tick($sformatf("vec%0d_latch", i));
      run_frame($sformatf("vec%0d", i), -1, '0, '0, vecs[i].balls);
    end

    pos_x = 10'd10; pos_y = 10'd5;
    wait_tick("mid_latch");
    run_frame("mid_old", 600, 10'd37, 10'd27, 36);
    run_frame("mid_new", -1, '0, '0, 9);

    en_mode = 1;
    pos_x = 10'd38; pos_y = 10'd0;
    wait_tick("duty_latch");
    run_frame("duty", -1, '0, '0, 12);

    en_mode = 2;
    repeat (6000) @(negedge clk);
    en_mode = 0;

    found = 0; guard = 0;
    while (!found && guard < 2 * SFRAME) begin
      @(negedge clk);
      guard++;
      found = ((s_n % SFRAME) == 15 * SHT + 20);
    end
    check_output("mid_reset_reach", {31'b0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_reset_de", {31'b0, s_de}, 32'd0);
    check_output("mid_reset_rgb", {20'b0, s_rgb}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("restart_rgb", {20'b0, s_rgb}, {20'b0, SBALL});
    check_output("restart_big_rgb", {20'b0, b_rgb}, 32'h0000_0F00);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b1;
    pos_x = '0;
    pos_y = '0;
    apply_stimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
